// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI codes, FSM state type and burst range helper
package axi_pkg;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [2:0] SIZE_4B     = 3'b010;

   typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_WRESP, ST_READ} state_t;
   typedef enum logic {PRIO_READ, PRIO_WRITE} prio_t;

   // True when every beat address of the burst lies in [base, base+bytes).
   function automatic logic burst_in_range(input logic [31:0] addr, input logic [7:0] len,
                                           input logic [1:0] burst, input logic [31:0] base,
                                           input logic [32:0] bytes);
      logic [33:0] first_b;
      logic [33:0] last_b;
      first_b = {2'b00, addr};
      last_b  = first_b + ((burst == BURST_INCR) ? {24'b0, len, 2'b00} : 34'd0);
      return (first_b >= {2'b00, base}) && (last_b < ({2'b00, base} + {1'b0, bytes}));
   endfunction
endpackage

// File: rtl/sp_ram_bytewr.sv
// rtl/sp_ram_bytewr.sv - single-port DEPTH x 32 RAM, byte write enables, registered read
module sp_ram_bytewr #(
   parameter int    DEPTH     = 16384,
   parameter int    AW        = 14,
   parameter string INIT_FILE = ""
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_re,
   input  logic [3:0]    i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);
   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_q;

   // Only the output register is reset; array contents survive reset.
   always_ff @(posedge i_clk) begin
      for (int b = 0; b < 4; b++) begin
         if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
      if (i_rst)     r_q <= '0;
      else if (i_re) r_q <= r_mem[i_addr];
   end

   assign o_rdata = r_q;
endmodule

// File: rtl/axi_burst_mem_slave.sv
// rtl/axi_burst_mem_slave.sv - AXI4 INCR/FIXED burst slave over byte-writable on-chip RAM
module axi_burst_mem_slave
   import axi_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter int          MEM_BYTES = 2**16,
   parameter string       INIT_FILE = ""
) (
   input  logic        i_aclk,
   input  logic        i_areset,
   input  logic        i_awvalid,
   output logic        o_awready,
   input  logic [1:0]  i_awburst,
   input  logic [2:0]  i_awsize,
   input  logic [7:0]  i_awlen,
   input  logic [31:0] i_awaddr,
   input  logic        i_arvalid,
   output logic        o_arready,
   input  logic [1:0]  i_arburst,
   input  logic [2:0]  i_arsize,
   input  logic [7:0]  i_arlen,
   input  logic [31:0] i_araddr,
   input  logic        i_wvalid,
   output logic        o_wready,
   input  logic        i_wlast,
   input  logic [7:0]  i_wstrb,
   input  logic [31:0] i_wdata,
   output logic        o_bvalid,
   output logic [1:0]  o_bresp,
   input  logic        i_bready,
   output logic        o_rvalid,
   output logic        o_rlast,
   output logic [31:0] o_rdata,
   input  logic        i_rready
);
   localparam int DEPTH = MEM_BYTES / 4;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t      r_state, w_next;
   prio_t       r_prio;
   logic [31:0] r_addr;
   logic [7:0]  r_len;
   logic [1:0]  r_burst;
   logic [8:0]  r_cnt;
   logic        r_err, r_rvalid, r_rlast;

   logic [31:0]   w_req_addr, w_ram_q;
   logic [7:0]    w_req_len;
   logic [1:0]    w_req_burst;
   logic [2:0]    w_req_size;
   logic          w_req_err, w_w_hs, w_re, w_last_beat, w_unused;
   logic [3:0]    w_we;
   logic [AW-1:0] w_idx;

   assign w_unused    = ^i_wstrb[7:4];
   assign w_last_beat = (r_cnt == {1'b0, r_len});
   assign w_w_hs      = (r_state == ST_WRITE) && i_wvalid;
   assign w_re        = (r_state == ST_READ) && (!r_rvalid || i_rready) && (r_cnt <= {1'b0, r_len});
   assign w_we        = (w_w_hs && !r_err) ? i_wstrb[3:0] : 4'b0000;
   assign w_idx       = (DEPTH > 1) ? AW'((r_addr - BASE_ADDR) >> 2) : '0;

   assign w_req_addr  = o_arready ? i_araddr  : i_awaddr;
   assign w_req_len   = o_arready ? i_arlen   : i_awlen;
   assign w_req_burst = o_arready ? i_arburst : i_awburst;
   assign w_req_size  = o_arready ? i_arsize  : i_awsize;
   assign w_req_err   = (w_req_size != SIZE_4B) || w_req_burst[1] ||
                        !burst_in_range(w_req_addr, w_req_len, w_req_burst, BASE_ADDR, 33'(MEM_BYTES));

   always_ff @(posedge i_aclk) begin
      if (i_areset) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      o_awready = 1'b0;
      o_arready = 1'b0;
      o_wready  = 1'b0;
      o_bvalid  = 1'b0;
      o_bresp   = RESP_OKAY;
      case (r_state)
         ST_IDLE: begin
            o_awready = i_awvalid && (!i_arvalid || r_prio == PRIO_WRITE);
            o_arready = i_arvalid && (!i_awvalid || r_prio == PRIO_READ);
            if (o_arready)      w_next = ST_READ;
            else if (o_awready) w_next = ST_WRITE;
         end
         ST_WRITE: begin
            o_wready = 1'b1;
            if (i_wvalid && w_last_beat) w_next = ST_WRESP;
         end
         ST_WRESP: begin
            o_bvalid = 1'b1;
            o_bresp  = r_err ? RESP_SLVERR : RESP_OKAY;
            if (i_bready) w_next = ST_IDLE;
         end
         ST_READ: begin
            if (r_rvalid && i_rready && r_rlast) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_aclk) begin
      if (i_areset) begin
         r_prio   <= PRIO_READ;
         r_addr   <= '0;
         r_len    <= '0;
         r_burst  <= BURST_FIXED;
         r_cnt    <= '0;
         r_err    <= 1'b0;
         r_rvalid <= 1'b0;
         r_rlast  <= 1'b0;
      end else begin
         if (r_state == ST_IDLE && i_awvalid && i_arvalid)
            r_prio <= (r_prio == PRIO_READ) ? PRIO_WRITE : PRIO_READ;
         if (o_awready || o_arready) begin
            r_addr  <= w_req_addr;
            r_len   <= w_req_len;
            r_burst <= w_req_burst;
            r_cnt   <= '0;
            r_err   <= w_req_err;
         end
         // Beat count alone ends a write burst; a misplaced wlast only flags the response.
         if (w_w_hs) begin
            r_cnt <= r_cnt + 9'd1;
            if (r_burst == BURST_INCR) r_addr <= r_addr + 32'd4;
            if (i_wlast != w_last_beat) r_err <= 1'b1;
         end
         if (w_re) begin
            r_cnt    <= r_cnt + 9'd1;
            if (r_burst == BURST_INCR) r_addr <= r_addr + 32'd4;
            r_rvalid <= 1'b1;
            r_rlast  <= w_last_beat;
         end else if (i_rready) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
         end
      end
   end

   sp_ram_bytewr #(.DEPTH(DEPTH), .AW(AW), .INIT_FILE(INIT_FILE)) u_ram (
      .i_clk   (i_aclk),
      .i_rst   (i_areset),
      .i_re    (w_re),
      .i_we    (w_we),
      .i_addr  (w_idx),
      .i_wdata (i_wdata),
      .o_rdata (w_ram_q)
   );

   assign o_rvalid = r_rvalid;
   assign o_rlast  = r_rlast;
   assign o_rdata  = r_err ? 32'h0 : w_ram_q;
endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// tb/tb_axi_burst_mem_slave.sv - randomized self-checking bench with a word-array memory model
module tb_axi_burst_mem_slave;
   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          MEMB  = 1024;
   localparam int          DEPTH = MEMB / 4;

   logic        clk = 1'b0;
   logic        areset;
   logic        awvalid, awready, arvalid, arready;
   logic [1:0]  awburst, arburst;
   logic [2:0]  awsize, arsize;
   logic [7:0]  awlen, arlen;
   logic [31:0] awaddr, araddr;
   logic        wvalid, wready, wlast;
   logic [7:0]  wstrb;
   logic [31:0] wdata;
   logic        bvalid, bready;
   logic [1:0]  bresp;
   logic        rvalid, rlast, rready;
   logic [31:0] rdata;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] wq_data [$];
   logic [3:0]  wq_strb [$];
   logic [31:0] last_rdata;

   always #5 clk = ~clk;

   axi_burst_mem_slave #(.BASE_ADDR(BASE), .MEM_BYTES(MEMB), .INIT_FILE("")) dut (
      .i_aclk(clk), .i_areset(areset),
      .i_awvalid(awvalid), .o_awready(awready), .i_awburst(awburst), .i_awsize(awsize),
      .i_awlen(awlen), .i_awaddr(awaddr),
      .i_arvalid(arvalid), .o_arready(arready), .i_arburst(arburst), .i_arsize(arsize),
      .i_arlen(arlen), .i_araddr(araddr),
      .i_wvalid(wvalid), .o_wready(wready), .i_wlast(wlast), .i_wstrb(wstrb), .i_wdata(wdata),
      .o_bvalid(bvalid), .o_bresp(bresp), .i_bready(bready),
      .o_rvalid(rvalid), .o_rlast(rlast), .o_rdata(rdata), .i_rready(rready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit exp_err(input logic [31:0] a, input int len, input logic [1:0] b,
                                  input logic [2:0] s);
      longint first_a, last_a;
      first_a = longint'({32'b0, a});
      last_a  = first_a + ((b == 2'b01) ? 4 * len : 0);
      return (s != 3'b010) || (b > 2'b01) || (first_a < longint'({32'b0, BASE})) ||
             (last_a >= longint'({32'b0, BASE}) + MEMB);
   endfunction

   function automatic int widx(input logic [31:0] a, input int k, input logic [1:0] b);
      return (int'((a - BASE) >> 2) + ((b == 2'b01) ? k : 0)) % DEPTH;
   endfunction

   task automatic aw_issue(input logic [31:0] a, input int len, input logic [1:0] b, input logic [2:0] s);
      int g = 0;
      awvalid = 1'b1; awaddr = a; awlen = 8'(len); awburst = b; awsize = s;
      @(negedge clk);
      while (!awready && g < 50) begin @(negedge clk); g++; end
      chk("aw_grant", awready, 1);
      @(posedge clk); #1; awvalid = 1'b0;
   endtask

   task automatic ar_issue(input logic [31:0] a, input int len, input logic [1:0] b, input logic [2:0] s);
      int g = 0;
      arvalid = 1'b1; araddr = a; arlen = 8'(len); arburst = b; arsize = s;
      @(negedge clk);
      while (!arready && g < 50) begin @(negedge clk); g++; end
      chk("ar_grant", arready, 1);
      @(posedge clk); #1; arvalid = 1'b0;
   endtask

   task automatic w_phase(input logic [31:0] a, input int len, input logic [1:0] b,
                          input logic [2:0] s, input bit early);
      int n = 0, g = 0, idx;
      bit err, done = 0;
      err = exp_err(a, len, b, s) || early;
      while (n <= len && g < 3000) begin
         wvalid = ($urandom_range(0, 3) != 0);
         wdata  = wq_data[n];
         wstrb  = {4'($urandom), wq_strb[n]};
         wlast  = (n == len) || (early && n == 0);
         @(negedge clk);
         if (wvalid && wready) begin
            if (!err) begin
               idx = widx(a, n, b);
               for (int i = 0; i < 4; i++)
                  if (wq_strb[n][i]) ref_mem[idx][8*i +: 8] = wq_data[n][8*i +: 8];
            end
            n++;
         end
         @(posedge clk); #1; g++;
      end
      wvalid = 1'b0; wlast = 1'b0;
      chk("w_beats", n, len + 1);
      g = 0;
      while (!done && g < 50) begin
         bready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (bvalid && bready) begin
            chk("bresp", bresp, err ? 2 : 0);
            done = 1;
         end
         @(posedge clk); #1; g++;
      end
      bready = 1'b0;
      chk("b_done", done, 1);
      wq_data.delete(); wq_strb.delete();
   endtask

   task automatic r_collect(input logic [31:0] a, input int len, input logic [1:0] b,
                            input logic [2:0] s, input int mode);
      int n = 0, cyc = 0, first = -1;
      bit err;
      logic [31:0] e;
      err = exp_err(a, len, b, s);
      while (n <= len && cyc < 3000) begin
         case (mode)
            0:       rready = 1'b1;
            1:       rready = (cyc % 3 == 0);
            default: rready = 1'($urandom_range(0, 1));
         endcase
         @(negedge clk); cyc++;
         if (rvalid && first < 0) first = cyc;
         if (rvalid) begin
            if (err) e = 32'h0;
            else     e = ref_mem[widx(a, n, b)];
            chk("rdata", rdata, e);
            chk("rlast", rlast, n == len);
            if (rready) begin last_rdata = rdata; n++; end
         end
         @(posedge clk); #1;
      end
      rready = 1'b0;
      chk("r_beats", n, len + 1);
      chk("r_latency", first, 2);
      @(negedge clk);
      chk("r_idle", rvalid, 0);
      @(posedge clk); #1;
   endtask

   task automatic do_write(input logic [31:0] a, input int len, input logic [1:0] b,
                           input logic [2:0] s, input bit early);
      aw_issue(a, len, b, s);
      w_phase(a, len, b, s, early);
   endtask

   task automatic do_read(input logic [31:0] a, input int len, input logic [1:0] b,
                          input logic [2:0] s, input int mode);
      ar_issue(a, len, b, s);
      r_collect(a, len, b, s, mode);
   endtask

   task automatic push_beats(input int len, input bit rand_strb);
      for (int i = 0; i <= len; i++) begin
         wq_data.push_back($urandom);
         wq_strb.push_back(rand_strb ? 4'($urandom) : 4'hF);
      end
   endtask

   initial begin
      logic [31:0] a;
      int          len;
      logic [1:0]  b;
      logic [2:0]  s;

      areset = 1'b1;
      awvalid = 0; awburst = 0; awsize = 0; awlen = 0; awaddr = 0;
      arvalid = 0; arburst = 0; arsize = 0; arlen = 0; araddr = 0;
      wvalid = 0; wlast = 0; wstrb = 0; wdata = 0; bready = 0; rready = 0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_awready", awready, 0);
      chk("rst_arready", arready, 0);
      chk("rst_wready", wready, 0);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_bresp", bresp, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rlast", rlast, 0);
      chk("rst_rdata", rdata, 0);
      @(posedge clk); #1; areset = 1'b0;

      // Fill the whole RAM with one maximum-length burst so the model is fully defined.
      push_beats(255, 0);
      do_write(BASE, 255, 2'b01, 3'b010, 0);
      do_read(BASE, 255, 2'b01, 3'b010, 2);

      for (int i = 0; i < 4; i++) begin
         wq_data.push_back(32'hA0 + 32'(i)); wq_strb.push_back(4'hF);
      end
      do_write(BASE + 32'h10, 3, 2'b01, 3'b010, 0);
      do_read(BASE + 32'h10, 3, 2'b01, 3'b010, 0);

      wq_data.push_back(32'h11223344); wq_strb.push_back(4'hF);
      do_write(BASE + 32'h20, 0, 2'b01, 3'b010, 0);
      wq_data.push_back(32'hFFFFFFFF); wq_strb.push_back(4'h5);
      do_write(BASE + 32'h20, 0, 2'b01, 3'b010, 0);
      do_read(BASE + 32'h20, 0, 2'b01, 3'b010, 0);
      chk("merge_word", last_rdata, 32'h11FF33FF);

      do_read(BASE + 32'h40, 7, 2'b01, 3'b010, 1);

      awvalid = 1; awaddr = BASE + 32'h80; awlen = 0; awburst = 2'b01; awsize = 3'b010;
      arvalid = 1; araddr = BASE + 32'h84; arlen = 0; arburst = 2'b01; arsize = 3'b010;
      @(negedge clk);
      chk("arb1_arready", arready, 1);
      chk("arb1_awready", awready, 0);
      @(posedge clk); #1; awvalid = 0; arvalid = 0;
      r_collect(BASE + 32'h84, 0, 2'b01, 3'b010, 0);
      awvalid = 1; arvalid = 1;
      @(negedge clk);
      chk("arb2_awready", awready, 1);
      chk("arb2_arready", arready, 0);
      @(posedge clk); #1; awvalid = 0; arvalid = 0;
      wq_data.push_back(32'hCAFEF00D); wq_strb.push_back(4'hF);
      w_phase(BASE + 32'h80, 0, 2'b01, 3'b010, 0);
      do_read(BASE + 32'h80, 0, 2'b01, 3'b010, 0);

      // Range, size, burst-type and wlast error cases, plus in-range boundary bursts.
      push_beats(0, 0); do_write(BASE + MEMB, 0, 2'b01, 3'b010, 0);
      do_read(BASE, 0, 2'b01, 3'b010, 0);
      push_beats(0, 0); do_write(BASE + 32'h30, 0, 2'b01, 3'b001, 0);
      do_read(BASE + 32'h30, 0, 2'b01, 3'b010, 0);
      push_beats(3, 0); do_write(BASE + MEMB - 8, 3, 2'b01, 3'b010, 0);
      do_read(BASE + MEMB - 8, 1, 2'b01, 3'b010, 0);
      push_beats(3, 0); do_write(BASE + MEMB - 4, 3, 2'b00, 3'b010, 0);
      do_read(BASE + MEMB - 4, 2, 2'b00, 3'b010, 0);
      push_beats(1, 0); do_write(BASE + 32'h50, 1, 2'b10, 3'b010, 0);
      do_read(BASE + 32'h50, 1, 2'b01, 3'b010, 0);
      push_beats(0, 0); do_write(BASE + MEMB - 4, 0, 2'b01, 3'b010, 0);
      do_read(BASE - 4, 0, 2'b01, 3'b010, 0);
      do_read(BASE + MEMB - 8, 3, 2'b01, 3'b010, 2);
      do_read(BASE + MEMB - 4, 0, 2'b01, 3'b010, 0);
      for (int i = 0; i < 3; i++) begin wq_data.push_back($urandom); wq_strb.push_back(4'h0); end
      do_write(BASE + 32'h60, 2, 2'b01, 3'b010, 1);

      for (int it = 0; it < 30; it++) begin
         len = $urandom_range(0, 15);
         a = BASE + 32'($urandom_range(0, 255) * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) != 0) ? BASE + MEMB + 32'($urandom_range(0, 64)) : BASE - 4;
         b = ($urandom_range(0, 9) == 0) ? 2'b10 : (($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01);
         s = ($urandom_range(0, 9) == 0) ? 3'b001 : 3'b010;
         if ($urandom_range(0, 1) != 0) begin
            push_beats(len, 1);
            do_write(a, len, b, s, 0);
         end else begin
            do_read(a, len, b, s, 2);
         end
      end

      // Reset while beat 2 of a 4-beat read is on the bus.
      ar_issue(BASE + 32'h40, 3, 2'b01, 3'b010);
      rready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_beat2_valid", rvalid, 1);
      chk("mid_beat2_data", rdata, ref_mem[widx(BASE + 32'h40, 1, 2'b01)]);
      areset = 1'b1;
      arvalid = 1; araddr = BASE + 32'h100; arlen = 2; arburst = 2'b01; arsize = 3'b010;
      @(posedge clk); #1; areset = 1'b0; rready = 1'b0;
      @(negedge clk);
      chk("post_rst_rvalid", rvalid, 0);
      chk("post_rst_arready", arready, 1);
      @(posedge clk); #1; arvalid = 0;
      r_collect(BASE + 32'h100, 2, 2'b01, 3'b010, 0);
      push_beats(1, 1); do_write(BASE + 32'h104, 1, 2'b01, 3'b010, 0);
      do_read(BASE + 32'h100, 3, 2'b01, 3'b010, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
